// File: rtl/rob.sv
`default_nettype none
// ============================================================================
//  Module   : rob
//  Purpose  : Reorder buffer. Allocates tags, records CDB completions, retires
//             strictly in program order, and serves issue-stage operand lookups.
//  Revision : 1.0  initial release
// ============================================================================
module rob #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [1:0]              issue_kind,
    input  logic [REG_WIDTH-1:0]    issue_reg,
    output logic [ROB_WIDTH-1:0]    issue_tag,
    input  logic                    gpr_cdb_valid,
    input  logic [ROB_WIDTH-1:0]    gpr_cdb_tag,
    input  logic [DATA_WIDTH-1:0]   gpr_cdb_data,
    input  logic                    fpr_cdb_valid,
    input  logic [ROB_WIDTH-1:0]    fpr_cdb_tag,
    input  logic [DATA_WIDTH-1:0]   fpr_cdb_data,
    input  logic [2*ROB_WIDTH-1:0]  lookup_tag,
    output logic [1:0]              lookup_valid,
    output logic [2*DATA_WIDTH-1:0] lookup_data,
    output logic                    gpr_commit_valid,
    output logic                    fpr_commit_valid,
    output logic [REG_WIDTH-1:0]    commit_reg,
    output logic [ROB_WIDTH-1:0]    commit_tag,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic                    sw_commit_valid,
    input  logic                    sw_commit_ready
);

    localparam int                 c_depth      = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] c_depth_cnt  = (ROB_WIDTH+1)'(c_depth);
    localparam logic [1:0]         c_kind_gpr   = 2'd0;
    localparam logic [1:0]         c_kind_fpr   = 2'd1;
    localparam logic [1:0]         c_kind_store = 2'd2;

    logic [ROB_WIDTH-1:0]  r_head;
    logic [ROB_WIDTH-1:0]  r_tail;
    logic [ROB_WIDTH:0]    r_count;
    logic                  r_done [c_depth];
    logic [1:0]            r_kind [c_depth];
    logic [REG_WIDTH-1:0]  r_reg  [c_depth];
    logic [DATA_WIDTH-1:0] r_data [c_depth];

    logic       w_alloc_fire;
    logic       w_nonempty;
    logic [1:0] w_head_kind;
    logic       w_commit_fire;

    assign issue_ready     = (r_count < c_depth_cnt);
    assign issue_tag       = r_tail;
    assign w_alloc_fire    = issue_valid && issue_ready;
    assign w_nonempty      = (r_count != '0);
    assign w_head_kind     = r_kind[r_head];
    assign sw_commit_valid = w_nonempty && (w_head_kind == c_kind_store);
    // A store at head blocks all retirement until the load/store unit accepts it.
    assign w_commit_fire   = sw_commit_valid ? sw_commit_ready
                                             : (w_nonempty && r_done[r_head]);

    // Allocation overrides any CDB hit on the same entry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) r_done[i] <= 1'b0;
        end else begin
            for (int i = 0; i < c_depth; i++) begin
                if (w_alloc_fire && r_tail == ROB_WIDTH'(i))
                    r_done[i] <= issue_kind[1];
                else if ((gpr_cdb_valid && gpr_cdb_tag == ROB_WIDTH'(i)) ||
                         (fpr_cdb_valid && fpr_cdb_tag == ROB_WIDTH'(i)))
                    r_done[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_depth; i++) begin
            if (w_alloc_fire && r_tail == ROB_WIDTH'(i)) begin
                r_kind[i] <= issue_kind;
                r_reg[i]  <= issue_reg;
            end else if (gpr_cdb_valid && gpr_cdb_tag == ROB_WIDTH'(i)) begin
                r_data[i] <= gpr_cdb_data;
            end else if (fpr_cdb_valid && fpr_cdb_tag == ROB_WIDTH'(i)) begin
                r_data[i] <= fpr_cdb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            gpr_commit_valid <= 1'b0;
            fpr_commit_valid <= 1'b0;
            commit_reg       <= '0;
            commit_tag       <= '0;
            commit_data      <= '0;
        end else begin
            if (w_alloc_fire)  r_tail <= r_tail + 1'b1;
            if (w_commit_fire) r_head <= r_head + 1'b1;
            case ({w_alloc_fire, w_commit_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            gpr_commit_valid <= w_commit_fire && (w_head_kind == c_kind_gpr);
            fpr_commit_valid <= w_commit_fire && (w_head_kind == c_kind_fpr);
            if (w_commit_fire && !w_head_kind[1]) begin
                commit_reg  <= r_reg[r_head];
                commit_tag  <= r_head;
                commit_data <= r_data[r_head];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lookup
        logic [ROB_WIDTH-1:0] w_tag;
        assign w_tag                                   = lookup_tag[g*ROB_WIDTH +: ROB_WIDTH];
        assign lookup_valid[g]                         = r_done[w_tag];
        assign lookup_data[g*DATA_WIDTH +: DATA_WIDTH] = r_data[w_tag];
    end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob
//  Purpose  : Directed self-checking bench for the reorder buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rob;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_kind;
    logic [4:0]  issue_reg;
    logic [3:0]  issue_tag;
    logic        gpr_cdb_valid;
    logic [3:0]  gpr_cdb_tag;
    logic [31:0] gpr_cdb_data;
    logic        fpr_cdb_valid;
    logic [3:0]  fpr_cdb_tag;
    logic [31:0] fpr_cdb_data;
    logic [7:0]  lookup_tag;
    logic [1:0]  lookup_valid;
    logic [63:0] lookup_data;
    logic        gpr_commit_valid;
    logic        fpr_commit_valid;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;
    logic        sw_commit_valid;
    logic        sw_commit_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob #(.ROB_WIDTH(4), .DATA_WIDTH(32), .REG_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_kind(issue_kind), .issue_reg(issue_reg), .issue_tag(issue_tag),
        .gpr_cdb_valid(gpr_cdb_valid), .gpr_cdb_tag(gpr_cdb_tag), .gpr_cdb_data(gpr_cdb_data),
        .fpr_cdb_valid(fpr_cdb_valid), .fpr_cdb_tag(fpr_cdb_tag), .fpr_cdb_data(fpr_cdb_data),
        .lookup_tag(lookup_tag), .lookup_valid(lookup_valid), .lookup_data(lookup_data),
        .gpr_commit_valid(gpr_commit_valid), .fpr_commit_valid(fpr_commit_valid),
        .commit_reg(commit_reg), .commit_tag(commit_tag), .commit_data(commit_data),
        .sw_commit_valid(sw_commit_valid), .sw_commit_ready(sw_commit_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid     = 1'b0;
        issue_kind      = 2'd0;
        issue_reg       = 5'd0;
        gpr_cdb_valid   = 1'b0;
        gpr_cdb_tag     = 4'd0;
        gpr_cdb_data    = 32'd0;
        fpr_cdb_valid   = 1'b0;
        fpr_cdb_tag     = 4'd0;
        fpr_cdb_data    = 32'd0;
        lookup_tag      = 8'd0;
        sw_commit_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rg);
        issue_valid = 1'b1;
        issue_kind  = kind;
        issue_reg   = rg;
        cyc();
        issue_valid = 1'b0;
    endtask

    int n_commits;

    initial begin
        do_reset();
        #1;
        chk("rst_ready", issue_ready, 1);
        chk("rst_tag", issue_tag, 0);
        chk("rst_gpr_cv", gpr_commit_valid, 0);
        chk("rst_fpr_cv", fpr_commit_valid, 0);
        chk("rst_sw_cv", sw_commit_valid, 0);
        chk("rst_creg", commit_reg, 0);
        chk("rst_ctag", commit_tag, 0);
        chk("rst_cdata", commit_data, 0);

        // Fill all 16 entries, nothing completes.
        for (int i = 0; i < 16; i++) begin
            issue_valid = 1'b1;
            issue_kind  = 2'd0;
            issue_reg   = 5'(i);
            #1;
            chk("fill_tag", issue_tag, i);
            chk("fill_ready", issue_ready, 1);
            cyc();
        end
        #1;
        chk("full_ready", issue_ready, 0);
        cyc();
        chk("full_no_alloc_tag", issue_tag, 0);
        chk("full_no_commit", gpr_commit_valid, 0);

        // Full with head completing: allocation waits one cycle past the retire.
        gpr_cdb_valid = 1'b1; gpr_cdb_tag = 4'd0; gpr_cdb_data = 32'h0000_00AA;
        issue_reg = 5'd9;
        #1;
        chk("full_cdb_ready", issue_ready, 0);
        cyc();
        gpr_cdb_valid = 1'b0;
        #1;
        chk("full_retire_ready", issue_ready, 0);
        cyc();
        chk("full_after_ready", issue_ready, 1);
        chk("full_after_tag", issue_tag, 0);
        chk("full_commit_v", gpr_commit_valid, 1);
        chk("full_commit_tag", commit_tag, 0);
        chk("full_commit_data", commit_data, 32'hAA);
        cyc();
        issue_valid = 1'b0;
        #1;
        chk("refill_tag", issue_tag, 1);
        chk("refill_ready", issue_ready, 0);
        chk("refill_no_commit", gpr_commit_valid, 0);

        // Out-of-order completion, in-order commit.
        do_reset();
        issue(2'd0, 5'd1);
        issue(2'd0, 5'd2);
        gpr_cdb_valid = 1'b1; gpr_cdb_tag = 4'd1; gpr_cdb_data = 32'h0000_BEEF;
        cyc();
        gpr_cdb_valid = 1'b0;
        lookup_tag = {4'd0, 4'd1};
        #1;
        chk("lk0_valid", lookup_valid[0], 1);
        chk("lk0_data", lookup_data[31:0], 32'hBEEF);
        chk("lk1_valid", lookup_valid[1], 0);
        cyc();
        chk("ooo_no_commit", gpr_commit_valid, 0);
        gpr_cdb_valid = 1'b1; gpr_cdb_tag = 4'd0; gpr_cdb_data = 32'h0000_1234;
        cyc();
        gpr_cdb_valid = 1'b0;
        chk("lat1_no_commit", gpr_commit_valid, 0);
        cyc();
        chk("c0_valid", gpr_commit_valid, 1);
        chk("c0_tag", commit_tag, 0);
        chk("c0_reg", commit_reg, 1);
        chk("c0_data", commit_data, 32'h1234);
        cyc();
        chk("c1_valid", gpr_commit_valid, 1);
        chk("c1_tag", commit_tag, 1);
        chk("c1_reg", commit_reg, 2);
        chk("c1_data", commit_data, 32'hBEEF);
        cyc();
        chk("c2_idle", gpr_commit_valid, 0);

        // Store stalls retirement until the LSU accepts.
        issue(2'd2, 5'd0);
        issue(2'd0, 5'd7);
        gpr_cdb_valid = 1'b1; gpr_cdb_tag = 4'd3; gpr_cdb_data = 32'h77;
        cyc();
        gpr_cdb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_sw", sw_commit_valid, 1);
            chk("st_wait_gpr", gpr_commit_valid, 0);
            cyc();
        end
        sw_commit_ready = 1'b1;
        #1;
        chk("st_accept_sw", sw_commit_valid, 1);
        cyc();
        sw_commit_ready = 1'b0;
        chk("st_done_sw", sw_commit_valid, 0);
        chk("st_no_strobe", gpr_commit_valid, 0);
        cyc();
        chk("st_gpr_v", gpr_commit_valid, 1);
        chk("st_gpr_tag", commit_tag, 3);
        chk("st_gpr_reg", commit_reg, 7);
        chk("st_gpr_data", commit_data, 32'h77);

        // 40 alternating GPR/FPR instructions, each completed the cycle after issue.
        do_reset();
        n_commits = 0;
        for (int cy = 0; cy < 52; cy++) begin
            issue_valid   = (cy < 40);
            issue_kind    = 2'(cy % 2);
            issue_reg     = 5'(cy);
            gpr_cdb_valid = (cy >= 1 && cy <= 40 && ((cy - 1) % 2 == 0));
            gpr_cdb_tag   = 4'((cy - 1) % 16);
            gpr_cdb_data  = 32'((cy - 1) * 32'h101 + 5);
            fpr_cdb_valid = (cy >= 1 && cy <= 40 && ((cy - 1) % 2 == 1));
            fpr_cdb_tag   = 4'((cy - 1) % 16);
            fpr_cdb_data  = 32'((cy - 1) * 32'h101 + 5);
            #1;
            if (cy < 40) chk("wrap_issue_tag", issue_tag, cy % 16);
            if (gpr_commit_valid || fpr_commit_valid) begin
                chk("wrap_ctag", commit_tag, n_commits % 16);
                chk("wrap_cdata", commit_data, n_commits * 32'h101 + 5);
                chk("wrap_is_fpr", fpr_commit_valid, n_commits % 2);
                n_commits++;
            end
            cyc();
        end
        idle_inputs();
        chk("wrap_commit_count", n_commits, 40);

        // Reset mid-operation with a ready head and a CDB in flight.
        do_reset();
        for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 10));
        gpr_cdb_valid = 1'b1; gpr_cdb_tag = 4'd0; gpr_cdb_data = 32'h11;
        cyc();
        reset = 1'b1;
        gpr_cdb_tag = 4'd2; gpr_cdb_data = 32'h55;
        cyc();
        reset = 1'b0;
        gpr_cdb_valid = 1'b0;
        lookup_tag = {4'd0, 4'd2};
        #1;
        chk("mrst_gpr_cv", gpr_commit_valid, 0);
        chk("mrst_fpr_cv", fpr_commit_valid, 0);
        chk("mrst_sw_cv", sw_commit_valid, 0);
        chk("mrst_ready", issue_ready, 1);
        chk("mrst_tag", issue_tag, 0);
        chk("mrst_lookup", lookup_valid[0], 0);
        cyc();
        chk("mrst_gpr_cv2", gpr_commit_valid, 0);
        issue(2'd0, 5'd3);
        chk("mrst_next_tag", issue_tag, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
